ahblite_arbiter: RTL

AHBLITE_ARBITER -- requirements
Module: ahblite_arbiter

---
 rtl/ahb_pkg.sv | 29 ++
 rtl/ahblite_arb_input_stage.sv | 47 ++++
 rtl/ahblite_arbiter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the address-phase record used by the arbiter.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;

  // Address-phase fields that must survive a stalled request.
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [3:0]  prot;
    logic        lock;
  } addr_phase_t;

  // NONSEQ and SEQ start a transfer; IDLE and BUSY do not.
  function automatic logic is_transfer(input logic [1:0] htrans);
    return htrans[1];
  endfunction

endpackage

// File: rtl/ahblite_arb_input_stage.sv
// Per-master request tracker: holds an address phase that could not be
// issued when the master presented it, so the master can be stalled safely.
module ahblite_arb_input_stage
  import ahb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  htrans,
  input  addr_phase_t live,
  input  logic        hreadyout,
  input  logic        take,
  output logic        req,
  output logic        pend_valid,
  output addr_phase_t sel
);

  logic        live_req_s;
  logic        pend_valid_r;
  addr_phase_t buf_r;

  assign live_req_s = is_transfer(htrans) & hreadyout;
  assign pend_valid = pend_valid_r;

  // Capture a live request that the arbiter did not take; drop the buffer once issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid_r <= 1'b0;
      buf_r        <= '0;
    end else if (take) begin
      pend_valid_r <= 1'b0;
    end else if (live_req_s) begin
      pend_valid_r <= 1'b1;
      buf_r        <= live;
    end
  end

  // Present the buffered phase in preference to the live bus.
  always_comb begin
    req = pend_valid_r | live_req_s;
    if (pend_valid_r) begin
      sel = buf_r;
    end else begin
      sel = live;
    end
  end

endmodule

// File: rtl/ahblite_arbiter.sv
// Two-master AHB-Lite arbiter (M0 = Cortex-M0, M1 = DMA) with round-robin
// grant, locked-sequence hold and per-master pending address buffers.
module ahblite_arbiter
  import ahb_pkg::*;
(
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] M0_HADDR,
  input  logic [1:0]  M0_HTRANS,
  input  logic        M0_HWRITE,
  input  logic [2:0]  M0_HSIZE,
  input  logic [2:0]  M0_HBURST,
  input  logic [3:0]  M0_HPROT,
  input  logic        M0_HMASTLOCK,
  input  logic [31:0] M0_HWDATA,
  output logic        M0_HREADYOUT,
  output logic [31:0] M0_HRDATA,
  output logic        M0_HRESP,
  input  logic [31:0] M1_HADDR,
  input  logic [1:0]  M1_HTRANS,
  input  logic        M1_HWRITE,
  input  logic [2:0]  M1_HSIZE,
  input  logic [2:0]  M1_HBURST,
  input  logic [3:0]  M1_HPROT,
  input  logic        M1_HMASTLOCK,
  input  logic [31:0] M1_HWDATA,
  output logic        M1_HREADYOUT,
  output logic [31:0] M1_HRDATA,
  output logic        M1_HRESP,
  output logic [31:0] S_HADDR,
  output logic [1:0]  S_HTRANS,
  output logic        S_HWRITE,
  output logic [2:0]  S_HSIZE,
  output logic [2:0]  S_HBURST,
  output logic [3:0]  S_HPROT,
  output logic        S_HMASTLOCK,
  output logic [31:0] S_HWDATA,
  output logic        S_HMASTER,
  input  logic        S_HREADY,
  input  logic [31:0] S_HRDATA,
  input  logic        S_HRESP
);

  addr_phase_t live_s [2];
  addr_phase_t sel_s  [2];
  addr_phase_t issued_s;
  logic [1:0]  req_s;
  logic [1:0]  pend_s;
  logic [1:0]  take_s;
  logic [1:0]  hreadyout_s;
  logic [1:0]  hresp_s;
  logic        grant_s;
  logic        issue_s;
  logic        data_owner_r;
  logic        data_valid_r;
  logic        last_grant_r;
  logic        lock_hold_r;
  logic        unused_s;

  // Every transfer is issued as SINGLE, so the masters' burst hints are not needed.
  assign unused_s = ^{M0_HBURST, M1_HBURST};

  assign live_s[0] = '{addr: M0_HADDR, write: M0_HWRITE, size: M0_HSIZE,
                       prot: M0_HPROT, lock: M0_HMASTLOCK};
  assign live_s[1] = '{addr: M1_HADDR, write: M1_HWRITE, size: M1_HSIZE,
                       prot: M1_HPROT, lock: M1_HMASTLOCK};

  ahblite_arb_input_stage u_in0 (
    .clk(HCLK), .rst_n(HRESETn), .htrans(M0_HTRANS), .live(live_s[0]),
    .hreadyout(hreadyout_s[0]), .take(take_s[0]),
    .req(req_s[0]), .pend_valid(pend_s[0]), .sel(sel_s[0])
  );

  ahblite_arb_input_stage u_in1 (
    .clk(HCLK), .rst_n(HRESETn), .htrans(M1_HTRANS), .live(live_s[1]),
    .hreadyout(hreadyout_s[1]), .take(take_s[1]),
    .req(req_s[1]), .pend_valid(pend_s[1]), .sel(sel_s[1])
  );

  // Grant decision; no issue while the slave stalls or reset is asserted.
  always_comb begin
    grant_s = last_grant_r;
    issue_s = 1'b0;
    if (!HRESETn || !S_HREADY) begin
      grant_s = last_grant_r;
      issue_s = 1'b0;
    end else if (lock_hold_r) begin
      grant_s = last_grant_r;
      issue_s = req_s[last_grant_r];
    end else if (req_s[0] && req_s[1]) begin
      grant_s = ~last_grant_r;
      issue_s = 1'b1;
    end else if (req_s[0]) begin
      grant_s = 1'b0;
      issue_s = 1'b1;
    end else if (req_s[1]) begin
      grant_s = 1'b1;
      issue_s = 1'b1;
    end else begin
      grant_s = last_grant_r;
      issue_s = 1'b0;
    end
    take_s[0] = issue_s & ~grant_s;
    take_s[1] = issue_s & grant_s;
  end

  // Drive the slave-side address phase from the granted master.
  always_comb begin
    issued_s = sel_s[grant_s];
    S_HBURST = HBURST_SINGLE;
    if (issue_s) begin
      S_HTRANS    = HTRANS_NONSEQ;
      S_HADDR     = issued_s.addr;
      S_HWRITE    = issued_s.write;
      S_HSIZE     = issued_s.size;
      S_HPROT     = issued_s.prot;
      S_HMASTLOCK = issued_s.lock;
      S_HMASTER   = grant_s;
    end else begin
      S_HTRANS    = HTRANS_IDLE;
      S_HADDR     = 32'h0000_0000;
      S_HWRITE    = 1'b0;
      S_HSIZE     = 3'b000;
      S_HPROT     = 4'b0000;
      S_HMASTLOCK = 1'b0;
      S_HMASTER   = last_grant_r;
    end
  end

  // Track the data-phase owner, round-robin history and lock ownership.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      data_owner_r <= 1'b0;
      data_valid_r <= 1'b0;
      last_grant_r <= 1'b1;
      lock_hold_r  <= 1'b0;
    end else if (issue_s) begin
      data_owner_r <= grant_s;
      data_valid_r <= 1'b1;
      last_grant_r <= grant_s;
      lock_hold_r  <= issued_s.lock;
    end else if (S_HREADY) begin
      data_valid_r <= 1'b0;
    end
  end

  // Per-master ready and response: only the data-phase owner sees the slave.
  always_comb begin
    for (int m = 0; m < 2; m++) begin
      if (data_valid_r && (data_owner_r == 1'(m))) begin
        hreadyout_s[m] = S_HREADY;
        hresp_s[m]     = S_HRESP;
      end else if (pend_s[m]) begin
        hreadyout_s[m] = 1'b0;
        hresp_s[m]     = HRESP_OKAY;
      end else begin
        hreadyout_s[m] = 1'b1;
        hresp_s[m]     = HRESP_OKAY;
      end
    end
  end

  // Write data follows the data-phase owner; quiet bus when no data phase.
  always_comb begin
    if (!data_valid_r) begin
      S_HWDATA = 32'h0000_0000;
    end else if (data_owner_r) begin
      S_HWDATA = M1_HWDATA;
    end else begin
      S_HWDATA = M0_HWDATA;
    end
  end

  assign M0_HREADYOUT = hreadyout_s[0];
  assign M1_HREADYOUT = hreadyout_s[1];
  assign M0_HRESP     = hresp_s[0];
  assign M1_HRESP     = hresp_s[1];
  assign M0_HRDATA    = S_HRDATA;
  assign M1_HRDATA    = S_HRDATA;

endmodule
